// File: rtl/gpu_pkg.sv
// Shared GPU definitions: program loader constants and state encoding, ISA opcodes.
package gpu_pkg;

   localparam logic [7:0] LOADER_MAGIC = 8'hA5;

   localparam logic [1:0] ERR_NONE         = 2'd0;
   localparam logic [1:0] ERR_BAD_COUNT    = 2'd1;
   localparam logic [1:0] ERR_BAD_CHECKSUM = 2'd2;

   typedef enum logic [2:0] {
      WAIT_MAGIC,
      COUNT_HI,
      COUNT_LO,
      PAYLOAD,
      CHECKSUM,
      DONE,
      ERROR
   } loader_state_t;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_BRANCH = 4'h1,
      OP_CMP    = 4'h2,
      OP_ADD    = 4'h3,
      OP_SUB    = 4'h4,
      OP_MUL    = 4'h5,
      OP_DIV    = 4'h6,
      OP_LDR    = 4'h7,
      OP_STR    = 4'h8,
      OP_CONST  = 4'h9,
      OP_RET    = 4'hF
   } opcode_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles payload bytes MSB-first into instruction words.
module byte_packer
   import gpu_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 32
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         clear,
   input  logic                         shift_en,
   input  logic [7:0]                   byte_in,
   output logic [INSTRUCTION_WIDTH-1:0] word,
   output logic                         at_last_byte,
   output logic                         word_complete
);

   localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
   localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   logic [CW-1:0] byte_cnt;

   assign at_last_byte  = (byte_cnt == CW'(BYTES_PER_WORD - 1));
   assign word_complete = shift_en && at_last_byte;

   // Shift each accepted byte in from the bottom so the first byte ends up on top.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
      end else if (shift_en) begin
         word     <= (word << 8) | INSTRUCTION_WIDTH'(byte_in);
         byte_cnt <= at_last_byte ? '0 : byte_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: parses a magic/count/payload/checksum frame into buffer writes.
module program_loader
   import gpu_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int INSTRUCTION_COUNT = 512
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic [7:0]                           byte_in,
   input  logic                                 byte_valid_in,
   output logic                                 byte_ready_out,
   output logic                                 wr_en_out,
   output logic [$clog2(INSTRUCTION_COUNT)-1:0] wr_addr_out,
   output logic [INSTRUCTION_WIDTH-1:0]         wr_data_out,
   output logic                                 loading_out,
   output logic                                 done_out,
   output logic                                 error_out,
   output logic [1:0]                           error_code_out,
   output logic [15:0]                          program_length_out
);

   localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
   localparam int AW = $clog2(INSTRUCTION_COUNT);

   loader_state_t state, next_state;

   logic          active;
   logic          accept;
   logic [7:0]    count_hi;
   logic [15:0]   count;
   logic [15:0]   count_rx;
   logic [7:0]    checksum;
   logic [AW-1:0] word_cnt;
   logic          at_last_byte;
   logic          word_complete;
   logic          last_word;

   logic          start_frame;
   logic          latch_hi;
   logic          latch_lo;
   logic          shift_en;
   logic          count_err;
   logic          sum_err;
   logic          sum_ok;

   assign byte_ready_out = active && (state != DONE);
   assign accept         = byte_valid_in && byte_ready_out;
   assign count_rx       = {count_hi, byte_in};
   assign last_word      = at_last_byte && (16'(word_cnt) == count - 16'd1);
   assign done_out       = (state == DONE);

   byte_packer #(
      .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
   ) u_packer (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .clear        (start_frame),
      .shift_en     (shift_en),
      .byte_in      (byte_in),
      .word         (wr_data_out),
      .at_last_byte (at_last_byte),
      .word_complete(word_complete)
   );

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= WAIT_MAGIC;
      else         state <= next_state;
   end

   // Next-state decode and per-byte control strobes.
   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      latch_hi    = 1'b0;
      latch_lo    = 1'b0;
      shift_en    = 1'b0;
      count_err   = 1'b0;
      sum_err     = 1'b0;
      sum_ok      = 1'b0;
      case (state)
         WAIT_MAGIC: begin
            if (accept && byte_in == LOADER_MAGIC) begin
               next_state  = COUNT_HI;
               start_frame = 1'b1;
            end
         end
         COUNT_HI: begin
            if (accept) begin
               latch_hi   = 1'b1;
               next_state = COUNT_LO;
            end
         end
         COUNT_LO: begin
            if (accept) begin
               latch_lo = 1'b1;
               if (count_rx == 16'd0 || count_rx > 16'(INSTRUCTION_COUNT)) begin
                  count_err  = 1'b1;
                  next_state = ERROR;
               end else begin
                  next_state = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (accept) begin
               shift_en = 1'b1;
               if (last_word) next_state = CHECKSUM;
            end
         end
         CHECKSUM: begin
            if (accept) begin
               if (byte_in == checksum) begin
                  sum_ok     = 1'b1;
                  next_state = DONE;
               end else begin
                  sum_err    = 1'b1;
                  next_state = ERROR;
               end
            end
         end
         DONE:    next_state = WAIT_MAGIC;
         ERROR:   next_state = WAIT_MAGIC;
         default: next_state = WAIT_MAGIC;
      endcase
   end

   // Frame datapath: counters, checksum, write strobe and status flags.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         active             <= 1'b0;
         count_hi           <= '0;
         count              <= '0;
         checksum           <= '0;
         word_cnt           <= '0;
         wr_en_out          <= 1'b0;
         wr_addr_out        <= '0;
         loading_out        <= 1'b0;
         error_out          <= 1'b0;
         error_code_out     <= ERR_NONE;
         program_length_out <= '0;
      end else begin
         active    <= 1'b1;
         wr_en_out <= word_complete;
         if (word_complete) begin
            wr_addr_out <= word_cnt;
            word_cnt    <= word_cnt + AW'(1);
         end
         if (start_frame) begin
            loading_out    <= 1'b1;
            error_out      <= 1'b0;
            error_code_out <= ERR_NONE;
            checksum       <= '0;
            word_cnt       <= '0;
         end
         if (latch_hi) count_hi <= byte_in;
         if (latch_lo) count    <= count_rx;
         if (shift_en) checksum <= checksum ^ byte_in;
         if (count_err || sum_err) begin
            loading_out    <= 1'b0;
            error_out      <= 1'b1;
            error_code_out <= count_err ? ERR_BAD_COUNT : ERR_BAD_CHECKSUM;
         end
         if (sum_ok) begin
            loading_out        <= 1'b0;
            program_length_out <= count;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a frame-level reference model.
module tb_program_loader;

   localparam int IW = 32;
   localparam int IC = 512;
   localparam int AW = 9;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid_in = 1'b0;
   logic          byte_ready_out;
   logic          wr_en_out;
   logic [AW-1:0] wr_addr_out;
   logic [IW-1:0] wr_data_out;
   logic          loading_out;
   logic          done_out;
   logic          error_out;
   logic [1:0]    error_code_out;
   logic [15:0]   program_length_out;

   int total = 0;
   int bad   = 0;

   logic [7:0]  frame_q[$];
   int          got_addr[$];
   logic [31:0] got_data[$];
   int          done_cnt = 0;

   int          exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_done;
   logic [1:0]  exp_code;
   logic [15:0] exp_len = 16'd0;

   program_loader #(
      .INSTRUCTION_WIDTH(IW),
      .INSTRUCTION_COUNT(IC)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .byte_in           (byte_in),
      .byte_valid_in     (byte_valid_in),
      .byte_ready_out    (byte_ready_out),
      .wr_en_out         (wr_en_out),
      .wr_addr_out       (wr_addr_out),
      .wr_data_out       (wr_data_out),
      .loading_out       (loading_out),
      .done_out          (done_out),
      .error_out         (error_out),
      .error_code_out    (error_code_out),
      .program_length_out(program_length_out)
   );

   always #5 clk_in = ~clk_in;

   // Record every buffer write and done pulse, sampled mid-cycle.
   always @(negedge clk_in) begin
      if (wr_en_out) begin
         got_addr.push_back(int'(wr_addr_out));
         got_data.push_back(wr_data_out);
      end
      if (done_out) done_cnt++;
   end

   task automatic clear_capture();
      @(posedge clk_in);
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard;
      bit sent;
      guard = 0;
      sent  = 0;
      while (!sent) begin
         @(negedge clk_in);
         if (stall && $urandom_range(0, 2) == 0) begin
            byte_valid_in = 1'b0;
         end else begin
            byte_valid_in = 1'b1;
            byte_in       = b;
            if (byte_ready_out) sent = 1;
         end
         guard++;
         if (!sent && guard > 50) begin
            total++; bad++;
            $display("[TB] FAIL handshake_timeout byte=%02h ready=%0b", b, byte_ready_out);
            sent = 1;
         end
      end
      @(posedge clk_in);
   endtask

   task automatic idle(input int n);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      repeat (n) @(negedge clk_in);
   endtask

   // Frame-level reference: decode count, payload words and checksum arithmetically.
   task automatic model();
      int cnt;
      logic [31:0] w;
      logic [7:0]  chk;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 0;
      cnt = int'(frame_q[1]) * 256 + int'(frame_q[2]);
      if (cnt == 0 || cnt > IC) begin
         exp_code = 2'd1;
      end else begin
         chk = 8'h00;
         for (int k = 0; k < cnt; k++) begin
            w = 32'd0;
            for (int j = 0; j < IW / 8; j++) begin
               w   = w * 256 + 32'(frame_q[3 + k * (IW / 8) + j]);
               chk = chk ^ frame_q[3 + k * (IW / 8) + j];
            end
            exp_addr.push_back(k);
            exp_data.push_back(w);
         end
         if (frame_q[3 + cnt * (IW / 8)] == chk) begin
            exp_done = 1;
            exp_code = 2'd0;
            exp_len  = 16'(cnt);
         end else begin
            exp_code = 2'd2;
         end
      end
   endtask

   task automatic build_frame(input int count_field, input int nwords, input bit bad_sum);
      logic [7:0] chk;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(count_field >> 8));
      frame_q.push_back(8'(count_field));
      chk = 8'h00;
      for (int i = 0; i < nwords * (IW / 8); i++) begin
         b = 8'($urandom);
         frame_q.push_back(b);
         chk = chk ^ b;
      end
      if (nwords > 0) frame_q.push_back(bad_sum ? (chk ^ 8'h01) : chk);
   endtask

   task automatic run_frame(input string name, input bit stall);
      int n;
      model();
      clear_capture();
      for (int i = 0; i < frame_q.size(); i++) begin
         send_byte(frame_q[i], stall);
         if (i == 0) begin
            #1;
            total++;
            if (loading_out !== 1'b1) begin
               bad++;
               $display("[TB] FAIL %s loading_after_magic got=%0b want=1", name, loading_out);
            end
         end
      end
      idle(5);
      total++;
      if (got_addr.size() !== exp_addr.size()) begin
         bad++;
         $display("[TB] FAIL %s write_count got=%0d want=%0d", name, got_addr.size(), exp_addr.size());
      end
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int k = 0; k < n; k++) begin
         total++;
         if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
            bad++;
            $display("[TB] FAIL %s write%0d got=(%0d,%08h) want=(%0d,%08h)", name, k,
                     got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
         end
      end
      total++;
      if (done_cnt !== int'(exp_done)) begin
         bad++;
         $display("[TB] FAIL %s done_pulses got=%0d want=%0d", name, done_cnt, exp_done);
      end
      total++;
      if (error_out !== (exp_code != 2'd0)) begin
         bad++;
         $display("[TB] FAIL %s error_out got=%0b want=%0b", name, error_out, exp_code != 2'd0);
      end
      total++;
      if (error_code_out !== exp_code) begin
         bad++;
         $display("[TB] FAIL %s error_code got=%0d want=%0d", name, error_code_out, exp_code);
      end
      total++;
      if (program_length_out !== exp_len) begin
         bad++;
         $display("[TB] FAIL %s program_length got=%0d want=%0d", name, program_length_out, exp_len);
      end
      total++;
      if (loading_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s loading_after_frame got=%0b want=0", name, loading_out);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [63:0] packed_out;
      packed_out = {byte_ready_out, wr_en_out, 7'(0), wr_addr_out, wr_data_out[15:0],
                    loading_out, done_out, error_out, error_code_out, program_length_out};
      total++;
      if (packed_out !== 64'd0 || wr_data_out !== 32'd0) begin
         bad++;
         $display("[TB] FAIL %s outputs_in_reset got rdy=%0b we=%0b a=%0d d=%08h ld=%0b dn=%0b e=%0b c=%0d len=%0d want all 0",
                  name, byte_ready_out, wr_en_out, wr_addr_out, wr_data_out, loading_out,
                  done_out, error_out, error_code_out, program_length_out);
      end
   endtask

   task automatic load_spec_frame(input logic [7:0] sum);
      logic [7:0] bytes [12];
      bytes = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h00, 8'h00, 8'h40,
                8'h50, 8'h00, 8'h01, 8'h00, 8'h00};
      bytes[11] = sum;
      frame_q.delete();
      for (int i = 0; i < 12; i++) frame_q.push_back(bytes[i]);
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_all_zero("reset");
      rst_in = 1'b1;
      @(negedge clk_in);
      total++;
      if (byte_ready_out !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_after_reset got=%0b want=1", byte_ready_out);
      end
   endtask

   task automatic test_good_frame();
      load_spec_frame(8'h21);
      run_frame("good_frame", 0);
      total++;
      if (exp_data.size() != 2 || exp_data[0] !== 32'h30000040 || exp_data[1] !== 32'h50000100) begin
         bad++;
         $display("[TB] FAIL good_frame_model_words got=%0d words want=2 (30000040,50000100)", exp_data.size());
      end
   endtask

   task automatic test_bad_checksum();
      load_spec_frame(8'h22);
      run_frame("bad_checksum", 0);
   endtask

   task automatic test_bad_count();
      frame_q = '{8'hA5, 8'h00, 8'h00};
      run_frame("count_zero", 0);
      frame_q = '{8'hA5, 8'h02, 8'h01};
      run_frame("count_513", 0);
   endtask

   task automatic test_noise_stall();
      clear_capture();
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 1);
      idle(3);
      total++;
      if (got_addr.size() !== 0 || done_cnt !== 0 || loading_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL noise_ignored got writes=%0d done=%0d loading=%0b want 0,0,0",
                  got_addr.size(), done_cnt, loading_out);
      end
      load_spec_frame(8'h21);
      run_frame("stalled_frame", 1);
   endtask

   task automatic test_magic_as_data();
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h12, 8'hA5,
                  8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h12};
      run_frame("magic_as_data", 1);
   endtask

   task automatic test_random();
      int nw;
      bit bs;
      for (int r = 0; r < 6; r++) begin
         nw = $urandom_range(1, 6);
         bs = ($urandom_range(0, 2) == 0);
         build_frame(nw, nw, bs);
         run_frame($sformatf("random%0d", r), bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid();
      build_frame(3, 3, 0);
      clear_capture();
      for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      check_all_zero("reset_mid");
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      exp_len = 16'd0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      for (int i = 8; i < frame_q.size(); i++) begin
         @(negedge clk_in);
         byte_valid_in = 1'b1;
         byte_in = frame_q[i];
      end
      idle(5);
      total++;
      if (got_addr.size() !== 0 || done_cnt !== 0) begin
         bad++;
         $display("[TB] FAIL reset_abandon got writes=%0d done=%0d want 0,0", got_addr.size(), done_cnt);
      end
      build_frame(4, 4, 0);
      run_frame("after_reset", 1);
   endtask

   task automatic test_full_depth();
      build_frame(IC, IC, 0);
      run_frame("full_depth", 0);
      total++;
      if (got_addr.size() == 0 || got_addr[got_addr.size() - 1] !== IC - 1) begin
         bad++;
         $display("[TB] FAIL full_depth_last_addr got=%0d want=%0d",
                  (got_addr.size() == 0) ? -1 : got_addr[got_addr.size() - 1], IC - 1);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_count();
      test_good_frame();
      test_noise_stall();
      test_magic_as_data();
      test_random();
      test_reset_mid();
      test_full_depth();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
